comparator_debounce_bank: RTL and testbench

Multi-channel, parametrised debouncer for the discrete-ADC comparator inputs. Each channel is synchronised into `clk` and passes through a runtime-programmable hold-count filter. Each channel produces a clean level, one-cycle rise/fall pulses, and a saturating count of rejected bounces. It sits between the comparator pins and the SAR/ramp control logic, replacing the fixed 3-sample debouncer.

---
 rtl/debounce_pkg.sv | 21 ++
 rtl/comparator_debounce_bank_if.sv | 36 +++
 rtl/debounce_channel.sv | 111 +++++++++++
 rtl/comparator_debounce_bank.sv | 67 ++++++
 tb/tb_comparator_debounce_bank.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared defaults and the per-channel decision type for the comparator
// debounce bank.
// -----------------------------------------------------------------------------
package debounce_pkg;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_GLITCH_W    = 8;

    // Outcome of one sample in a channel, handed from the decision logic to
    // the level/pulse and glitch-counter registers.
    typedef enum logic [1:0] {
        EVT_NONE,
        EVT_RISE,
        EVT_FALL,
        EVT_ABORT
    } db_evt_t;

endpackage

// File: rtl/comparator_debounce_bank_if.sv
// -----------------------------------------------------------------------------
// comparator_debounce_bank_if
// Signal bundle between the comparator debounce bank and its user.
//   comparator_in  raw asynchronous comparator levels
//   hold_cycles    consecutive differing samples needed to flip (0 acts as 1)
//   glitch_clear   synchronous clear of all glitch counters
//   comparator_db  debounced levels
//   rise / fall    one-cycle edge pulses per channel
//   glitch_count   packed per-channel rejected-bounce counts
// master: drives the inputs (controller side); slave: the debounce bank.
// -----------------------------------------------------------------------------
interface comparator_debounce_bank_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = debounce_pkg::DEF_CNT_W,
    parameter int GLITCH_W = debounce_pkg::DEF_GLITCH_W
);

    logic [CHANNELS-1:0]          comparator_in;
    logic [CNT_W-1:0]             hold_cycles;
    logic                         glitch_clear;
    logic [CHANNELS-1:0]          comparator_db;
    logic [CHANNELS-1:0]          rise;
    logic [CHANNELS-1:0]          fall;
    logic [CHANNELS*GLITCH_W-1:0] glitch_count;

    modport master (
        output comparator_in, hold_cycles, glitch_clear,
        input  comparator_db, rise, fall, glitch_count
    );

    modport slave (
        input  comparator_in, hold_cycles, glitch_clear,
        output comparator_db, rise, fall, glitch_count
    );

endinterface

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One comparator channel: synchroniser, hold counter, debounced level with
// registered rise/fall pulses, and a saturating glitch counter.
//   clk, reset_n   clock and async active-low reset
//   async_in       raw comparator input
//   threshold      effective hold count T (already forced to >= 1)
//   glitch_clear   synchronous clear of the glitch counter
//   db, rise, fall debounced level and edge pulses
//   glitch         rejected-bounce count
// -----------------------------------------------------------------------------
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GLITCH_W    = DEF_GLITCH_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                async_in,
    input  logic [CNT_W-1:0]    threshold,
    input  logic                glitch_clear,
    output logic                db,
    output logic                rise,
    output logic                fall,
    output logic [GLITCH_W-1:0] glitch
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [GLITCH_W-1:0]    glitch_q, glitch_d;
    logic                   db_q, db_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [CNT_W:0]         cnt_inc;
    logic                   s;
    db_evt_t                evt;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], async_in};
        // One extra bit so the compare stays correct at the top of the range.
        cnt_inc  = {1'b0, cnt_q} + 1'b1;
        evt      = EVT_NONE;
        cnt_d    = cnt_q;
        db_d     = db_q;
        glitch_d = glitch_q;

        if (s == db_q) begin
            if (cnt_q != '0) begin
                evt = EVT_ABORT;
            end
        end else if (cnt_inc >= {1'b0, threshold}) begin
            // >= so a threshold lowered mid-count flips on the next sample.
            evt = s ? EVT_RISE : EVT_FALL;
        end

        case (evt)
            EVT_ABORT: cnt_d = '0;
            EVT_RISE: begin
                cnt_d = '0;
                db_d  = 1'b1;
            end
            EVT_FALL: begin
                cnt_d = '0;
                db_d  = 1'b0;
            end
            default: begin
                if (s != db_q) begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
        endcase

        rise_d = (evt == EVT_RISE);
        fall_d = (evt == EVT_FALL);

        // Clear wins over a same-cycle abort.
        if (glitch_clear) begin
            glitch_d = '0;
        end else if (evt == EVT_ABORT && glitch_q != '1) begin
            glitch_d = glitch_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            glitch_q <= '0;
            db_q     <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            glitch_q <= glitch_d;
            db_q     <= db_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign db     = db_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign glitch = glitch_q;

endmodule

// File: rtl/comparator_debounce_bank.sv
// -----------------------------------------------------------------------------
// comparator_debounce_bank
// Bank of independent comparator debouncers sharing one hold-count setting.
//   clk      system clock (single domain)
//   reset_n  async active-low reset
//   bus      slave side of comparator_debounce_bank_if (inputs, levels,
//            pulses and packed glitch counts)
// -----------------------------------------------------------------------------
module comparator_debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GLITCH_W    = DEF_GLITCH_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    comparator_debounce_bank_if.slave  bus
);

    logic [CNT_W-1:0]          threshold;
    logic [CHANNELS-1:0]       db_v;
    logic [CHANNELS-1:0]       rise_v;
    logic [CHANNELS-1:0]       fall_v;
    logic [GLITCH_W-1:0]       glitch_v [CHANNELS];
    logic [CHANNELS*GLITCH_W-1:0] glitch_packed;

    // A hold count of 0 behaves like 1.
    always_comb begin
        threshold = bus.hold_cycles;
        if (bus.hold_cycles == '0) begin
            threshold = CNT_W'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .GLITCH_W    (GLITCH_W)
        ) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .async_in     (bus.comparator_in[i]),
            .threshold    (threshold),
            .glitch_clear (bus.glitch_clear),
            .db           (db_v[i]),
            .rise         (rise_v[i]),
            .fall         (fall_v[i]),
            .glitch       (glitch_v[i])
        );
    end

    always_comb begin
        glitch_packed = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            glitch_packed[i*GLITCH_W +: GLITCH_W] = glitch_v[i];
        end
    end

    assign bus.comparator_db = db_v;
    assign bus.rise          = rise_v;
    assign bus.fall          = fall_v;
    assign bus.glitch_count  = glitch_packed;

endmodule

// File: tb/tb_comparator_debounce_bank.sv
module tb_comparator_debounce_bank;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    comparator_debounce_bank_if #(.CHANNELS(4), .CNT_W(8), .GLITCH_W(8)) a ();
    comparator_debounce_bank_if #(.CHANNELS(1), .CNT_W(8), .GLITCH_W(2)) b ();

    comparator_debounce_bank #(
        .CHANNELS(4), .SYNC_STAGES(2), .CNT_W(8), .GLITCH_W(8)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (a)
    );

    comparator_debounce_bank #(
        .CHANNELS(1), .SYNC_STAGES(2), .CNT_W(8), .GLITCH_W(2)
    ) u_sat (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b)
    );

    int checks = 0;
    int errors = 0;
    logic sticky;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle pulse on the saturating instance, then four quiet edges.
    task automatic b_pulse();
        b.comparator_in = 1'b1;
        tick(1);
        b.comparator_in = 1'b0;
        tick(4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n         = 1'b0;
        a.comparator_in = 4'b0000;
        a.hold_cycles   = 8'd4;
        a.glitch_clear  = 1'b0;
        b.comparator_in = 1'b0;
        b.hold_cycles   = 8'd4;
        b.glitch_clear  = 1'b0;
        sticky          = 1'b0;

        // Reset state
        tick(2);
        chk("reset_db", 32'(a.comparator_db), 32'h0);
        chk("reset_rise", 32'(a.rise), 32'h0);
        chk("reset_fall", 32'(a.fall), 32'h0);
        chk("reset_glitch", a.glitch_count, 32'h0);
        reset_n = 1'b1;
        tick(2);

        // 1. Clean step on ch0, T=4: flip at edge 6
        a.comparator_in[0] = 1'b1;
        tick(5);
        chk("step_up_e5_db", 32'(a.comparator_db), 32'h0);
        tick(1);
        chk("step_up_e6_db", 32'(a.comparator_db), 32'h1);
        chk("step_up_e6_rise", 32'(a.rise), 32'h1);
        tick(1);
        chk("step_up_e7_rise", 32'(a.rise), 32'h0);
        chk("step_up_e7_db", 32'(a.comparator_db), 32'h1);
        a.comparator_in[0] = 1'b0;
        tick(5);
        chk("step_dn_e5_db", 32'(a.comparator_db), 32'h1);
        chk("step_dn_e5_fall", 32'(a.fall), 32'h0);
        tick(1);
        chk("step_dn_e6_db", 32'(a.comparator_db), 32'h0);
        chk("step_dn_e6_fall", 32'(a.fall), 32'h1);
        tick(1);
        chk("step_dn_e7_fall", 32'(a.fall), 32'h0);
        chk("step_glitch", a.glitch_count, 32'h0);

        // 2. Bounces of 1, 2, 3 cycles are rejected and counted
        sticky = 1'b0;
        for (int len = 1; len <= 3; len++) begin
            a.comparator_in[0] = 1'b1;
            for (int j = 0; j < len; j++) begin
                tick(1);
                sticky = sticky | a.comparator_db[0] | a.rise[0] | a.fall[0];
            end
            a.comparator_in[0] = 1'b0;
            for (int j = 0; j < 4; j++) begin
                tick(1);
                sticky = sticky | a.comparator_db[0] | a.rise[0] | a.fall[0];
            end
        end
        chk("bounce_no_activity", 32'(sticky), 32'h0);
        chk("bounce_glitch", a.glitch_count, 32'h3);

        // 3a. hold_cycles=0 acts as 1: flip at edge 3
        a.hold_cycles = 8'd0;
        a.comparator_in[0] = 1'b1;
        tick(2);
        chk("h0_up_e2_db", 32'(a.comparator_db), 32'h0);
        tick(1);
        chk("h0_up_e3_db", 32'(a.comparator_db), 32'h1);
        chk("h0_up_e3_rise", 32'(a.rise), 32'h1);
        a.comparator_in[0] = 1'b0;
        tick(2);
        chk("h0_dn_e2_db", 32'(a.comparator_db), 32'h1);
        tick(1);
        chk("h0_dn_e3_fall", 32'(a.fall), 32'h1);
        chk("h0_dn_e3_db", 32'(a.comparator_db), 32'h0);

        // 3b. hold 10 -> 2 while cnt=5 flips on the next edge
        a.hold_cycles = 8'd10;
        a.comparator_in[0] = 1'b1;
        tick(7);
        chk("lower_e7_db", 32'(a.comparator_db), 32'h0);
        a.hold_cycles = 8'd2;
        tick(1);
        chk("lower_e8_db", 32'(a.comparator_db), 32'h1);
        chk("lower_e8_rise", 32'(a.rise), 32'h1);
        a.hold_cycles = 8'd4;
        a.comparator_in[0] = 1'b0;
        tick(6);
        chk("lower_back_db", 32'(a.comparator_db), 32'h0);
        chk("lower_glitch", a.glitch_count, 32'h3);

        // 4. Saturation (GLITCH_W=2) and clear priority
        b_pulse();
        b_pulse();
        chk("sat_after2", 32'(b.glitch_count), 32'h2);
        b_pulse();
        b_pulse();
        b_pulse();
        chk("sat_after5", 32'(b.glitch_count), 32'h3);
        chk("sat_db", 32'(b.comparator_db), 32'h0);
        b.glitch_clear = 1'b1;
        tick(1);
        b.glitch_clear = 1'b0;
        chk("clear_alone", 32'(b.glitch_count), 32'h0);
        b_pulse();
        chk("clear_then_one", 32'(b.glitch_count), 32'h1);
        // abort lands on the 4th edge after the input is raised
        b.comparator_in = 1'b1;
        tick(1);
        b.comparator_in = 1'b0;
        tick(2);
        b.glitch_clear = 1'b1;
        tick(1);
        b.glitch_clear = 1'b0;
        chk("clear_with_abort", 32'(b.glitch_count), 32'h0);
        tick(3);
        chk("clear_with_abort_later", 32'(b.glitch_count), 32'h0);

        // 5. ch1 bounces every cycle while ch2 steps cleanly
        sticky = 1'b0;
        a.comparator_in = 4'b0110;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            sticky = sticky | a.comparator_db[1] | a.rise[1] | a.fall[1];
            if (k == 5) chk("indep_e5_db", 32'(a.comparator_db), 32'h0);
            if (k == 6) begin
                chk("indep_e6_db", 32'(a.comparator_db), 32'h4);
                chk("indep_e6_rise", 32'(a.rise), 32'h4);
            end
            a.comparator_in[1] = ((k + 1) % 2 == 1) && (k + 1 <= 11);
        end
        chk("indep_ch1_quiet", 32'(sticky), 32'h0);
        chk("indep_glitch", a.glitch_count, 32'h0000_0603);

        // 6. Reset mid-count (ch3 cnt=3) and mid-pulse
        a.comparator_in[3] = 1'b1;
        tick(5);
        chk("rst_pre_db", 32'(a.comparator_db), 32'h4);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_cnt_db", 32'(a.comparator_db), 32'h0);
        chk("rst_cnt_rise", 32'(a.rise), 32'h0);
        chk("rst_cnt_fall", 32'(a.fall), 32'h0);
        chk("rst_cnt_glitch", a.glitch_count, 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        chk("rel1_e1_rise", 32'(a.rise), 32'h0);
        tick(4);
        chk("rel1_e5_db", 32'(a.comparator_db), 32'h0);
        tick(1);
        chk("rel1_e6_db", 32'(a.comparator_db), 32'hC);
        chk("rel1_e6_rise", 32'(a.rise), 32'hC);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_pulse_rise", 32'(a.rise), 32'h0);
        chk("rst_pulse_db", 32'(a.comparator_db), 32'h0);
        tick(1);
        reset_n = 1'b1;
        tick(5);
        chk("rel2_e5_rise", 32'(a.rise), 32'h0);
        tick(1);
        chk("rel2_e6_rise", 32'(a.rise), 32'hC);
        tick(1);
        chk("rel2_e7_rise", 32'(a.rise), 32'h0);
        chk("rel2_e7_db", 32'(a.comparator_db), 32'hC);
        chk("rel2_fall", 32'(a.fall), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
